multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/cpu_pkg.sv | 53 +++++
 rtl/ctrl_out_decode.sv | 80 ++++++++
 rtl/multicycle_ctrl.sv | 80 ++++++++
 tb/tb_multicycle_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: controller states, opcodes and
// the ALU / PC-source select encodings.
package cpu_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [2:0] OP_RTYPE = 3'b000;
    localparam logic [2:0] OP_ADDI  = 3'b001;
    localparam logic [2:0] OP_SUBI  = 3'b010;
    localparam logic [2:0] OP_LW    = 3'b011;
    localparam logic [2:0] OP_SW    = 3'b100;
    localparam logic [2:0] OP_BEQ   = 3'b101;
    localparam logic [2:0] OP_JMP   = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_FUNC = 2'b10;

    localparam logic [1:0] PC_INC    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    typedef struct packed {
        logic [1:0] op;
        logic       src;
    } alu_ctl_t;

    // ALU setup an opcode uses in EXEC; WB repeats it so the result stays stable.
    function automatic alu_ctl_t exec_alu(input logic [2:0] opcode);
        alu_ctl_t c;
        c = '{op: ALU_ADD, src: 1'b0};
        case (opcode)
            OP_RTYPE: c = '{op: ALU_FUNC, src: 1'b0};
            OP_ADDI,
            OP_LW,
            OP_SW:    c = '{op: ALU_ADD, src: 1'b1};
            OP_SUBI:  c = '{op: ALU_SUB, src: 1'b1};
            OP_BEQ:   c = '{op: ALU_SUB, src: 1'b0};
            default:  c = '{op: ALU_ADD, src: 1'b0};
        endcase
        return c;
    endfunction

endpackage

// File: rtl/ctrl_out_decode.sv
// Combinational map from (state, opcode, zero, mem_ready)
// to the multicycle datapath control signals.
module ctrl_out_decode
    import cpu_pkg::*;
(
    input  state_t     state,
    input  logic [2:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] pc_src,
    output logic       mem_re,
    output logic       mem_we,
    output logic       mem_addr_sel,
    output logic       alu_src,
    output logic [1:0] alu_op,
    output logic       reg_we,
    output logic       wb_sel,
    output logic       halted
);

    alu_ctl_t alu;

    always_comb begin
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_src       = PC_INC;
        mem_re       = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        alu_src      = 1'b0;
        alu_op       = ALU_ADD;
        reg_we       = 1'b0;
        wb_sel       = 1'b0;
        halted       = 1'b0;
        alu          = exec_alu(opcode);
        unique case (state)
            S_FETCH: begin
                mem_re = 1'b1;
                if (mem_ready) begin
                    ir_we = 1'b1;
                    pc_we = 1'b1;
                end
            end
            S_DECODE: begin
                if (opcode == OP_JMP) begin
                    pc_we  = 1'b1;
                    pc_src = PC_JUMP;
                end
            end
            S_EXEC: begin
                if (opcode != OP_JMP && opcode != OP_HALT) begin
                    alu_op  = alu.op;
                    alu_src = alu.src;
                end
                if (opcode == OP_BEQ) begin
                    pc_src = PC_BRANCH;
                    pc_we  = zero;
                end
            end
            S_MEM: begin
                alu_op       = ALU_ADD;
                alu_src      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_re       = (opcode == OP_LW);
                mem_we       = (opcode == OP_SW);
            end
            S_WB: begin
                reg_we  = 1'b1;
                wb_sel  = (opcode == OP_LW);
                alu_op  = alu.op;
                alu_src = alu.src;
            end
            S_HALT: halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control unit: state register and next-state
// logic; outputs are decoded from the state by ctrl_out_decode.
module multicycle_ctrl
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [2:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] pc_src,
    output logic       mem_re,
    output logic       mem_we,
    output logic       mem_addr_sel,
    output logic       alu_src,
    output logic [1:0] alu_op,
    output logic       reg_we,
    output logic       wb_sel,
    output logic       halted,
    output logic [2:0] state
);

    state_t cur;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur <= S_IDLE;
        end else begin
            unique case (cur)
                S_IDLE:   if (start) cur <= S_FETCH;
                S_FETCH:  if (mem_ready) cur <= S_DECODE;
                S_DECODE: begin
                    if (opcode == OP_HALT)     cur <= S_HALT;
                    else if (opcode == OP_JMP) cur <= S_FETCH;
                    else                       cur <= S_EXEC;
                end
                S_EXEC: begin
                    if (opcode == OP_LW || opcode == OP_SW)
                        cur <= S_MEM;
                    else if (opcode == OP_RTYPE || opcode == OP_ADDI ||
                             opcode == OP_SUBI)
                        cur <= S_WB;
                    else
                        cur <= S_FETCH;
                end
                S_MEM: begin
                    if (mem_ready)
                        cur <= (opcode == OP_LW) ? S_WB : S_FETCH;
                end
                S_WB:    cur <= S_FETCH;
                S_HALT:  cur <= S_HALT;
                default: cur <= S_IDLE;
            endcase
        end
    end

    assign state = cur;

    ctrl_out_decode u_dec (
        .state        (cur),
        .opcode       (opcode),
        .zero         (zero),
        .mem_ready    (mem_ready),
        .ir_we        (ir_we),
        .pc_we        (pc_we),
        .pc_src       (pc_src),
        .mem_re       (mem_re),
        .mem_we       (mem_we),
        .mem_addr_sel (mem_addr_sel),
        .alu_src      (alu_src),
        .alu_op       (alu_op),
        .reg_we       (reg_we),
        .wb_sel       (wb_sel),
        .halted       (halted)
    );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: an instruction-level model
// queues the expected per-cycle outputs, a monitor compares them.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [2:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       ir_we, pc_we, mem_re, mem_we, mem_addr_sel;
    logic       alu_src, reg_we, wb_sel, halted;
    logic [1:0] pc_src, alu_op;
    logic [2:0] state;

    typedef struct packed {
        logic [2:0] st;
        logic       ir_we;
        logic       pc_we;
        logic [1:0] pc_src;
        logic       mem_re;
        logic       mem_we;
        logic       mem_addr_sel;
        logic       alu_src;
        logic [1:0] alu_op;
        logic       reg_we;
        logic       wb_sel;
        logic       halted;
    } obs_t;

    obs_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    multicycle_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .opcode       (opcode),
        .zero         (zero),
        .mem_ready    (mem_ready),
        .ir_we        (ir_we),
        .pc_we        (pc_we),
        .pc_src       (pc_src),
        .mem_re       (mem_re),
        .mem_we       (mem_we),
        .mem_addr_sel (mem_addr_sel),
        .alu_src      (alu_src),
        .alu_op       (alu_op),
        .reg_we       (reg_we),
        .wb_sel       (wb_sel),
        .halted       (halted),
        .state        (state)
    );

    always #5 clk = ~clk;

    function automatic obs_t observe();
        obs_t o;
        o = '{st: state, ir_we: ir_we, pc_we: pc_we, pc_src: pc_src,
              mem_re: mem_re, mem_we: mem_we, mem_addr_sel: mem_addr_sel,
              alu_src: alu_src, alu_op: alu_op, reg_we: reg_we,
              wb_sel: wb_sel, halted: halted};
        return o;
    endfunction

    function automatic obs_t mk(input int st);
        obs_t o;
        o = '0;
        o.st = 3'(st);
        return o;
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // Instruction table: ALU operation and operand source in EXEC.
    function automatic obs_t with_alu(input obs_t o, input int op);
        case (op)
            0:       begin o.alu_op = 2'b10; o.alu_src = 1'b0; end
            1, 3, 4: begin o.alu_op = 2'b00; o.alu_src = 1'b1; end
            2:       begin o.alu_op = 2'b01; o.alu_src = 1'b1; end
            5:       begin o.alu_op = 2'b01; o.alu_src = 1'b0; end
            default: ;
        endcase
        return o;
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            obs_t e, a;
            e = exp_q.pop_front();
            a = observe();
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL cycle-check %0d at %0t: got st=%0d bits=%h want st=%0d bits=%h",
                         vectors, $time, a.st, a, e.st, e);
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    task automatic cyc(input logic st, input logic mr, input obs_t e);
        start = st;
        mem_ready = mr;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // One instruction from FETCH; hang leaves a store stuck in MEM.
    task automatic run_instr(input int op, input logic z, input int fw,
                             input int mw, input bit hang = 1'b0);
        obs_t e;
        zero = z;
        for (int i = 0; i < fw; i++) begin
            opcode = 3'($urandom_range(0, 7));
            e = mk(1); e.mem_re = 1'b1;
            cyc(rb(), 1'b0, e);
        end
        opcode = 3'(op);
        e = mk(1); e.mem_re = 1'b1; e.ir_we = 1'b1; e.pc_we = 1'b1;
        cyc(rb(), 1'b1, e);
        e = mk(2);
        if (op == 6) begin e.pc_we = 1'b1; e.pc_src = 2'b10; end
        cyc(rb(), rb(), e);
        if (op == 6 || op == 7) return;
        e = with_alu(mk(3), op);
        if (op == 5) begin e.pc_src = 2'b01; e.pc_we = z; end
        cyc(rb(), rb(), e);
        if (op == 5) return;
        if (op == 3 || op == 4) begin
            e = mk(4); e.alu_src = 1'b1; e.mem_addr_sel = 1'b1;
            e.mem_re = (op == 3); e.mem_we = (op == 4);
            for (int i = 0; i < mw; i++) cyc(rb(), 1'b0, e);
            if (hang) return;
            cyc(rb(), 1'b1, e);
            if (op == 4) return;
        end
        e = with_alu(mk(5), op);
        e.reg_we = 1'b1;
        e.wb_sel = (op == 3);
        cyc(rb(), rb(), e);
    endtask

    task automatic idle_then_start(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, rb(), mk(0));
        cyc(1'b1, rb(), mk(0));
    endtask

    task automatic reset_now();
        #2 rst_n = 1'b0;
        #1 chk("reset_async", 16'(observe()), 16'(mk(0)));
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        obs_t e;
        rst_n = 1'b0;
        start = 1'b0;
        opcode = 3'd0;
        zero = 1'b0;
        mem_ready = 1'b0;
        #3 chk("reset_state", 16'(observe()), 16'(mk(0)));
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        idle_then_start(2);
        run_instr(0, 1'b0, 0, 0);
        run_instr(3, 1'b0, 0, 2);
        run_instr(5, 1'b1, 0, 0);
        run_instr(5, 1'b0, 0, 0);
        run_instr(6, 1'b0, 1, 0);
        for (int n = 0; n < 150; n++)
            run_instr($urandom_range(0, 6), rb(), $urandom_range(0, 3),
                      $urandom_range(0, 3));

        run_instr(7, rb(), 1, 0);
        for (int i = 0; i < 20; i++) begin
            opcode = 3'($urandom_range(0, 7));
            e = mk(6); e.halted = 1'b1;
            cyc(1'(i), rb(), e);
        end
        reset_now();

        idle_then_start(3);
        run_instr(4, rb(), 0, 2, 1'b1);
        mem_ready = 1'b0;
        start = 1'b0;
        chk("store_pending", {13'd0, state}, 16'd4);
        chk("store_we_high", {15'd0, mem_we}, 16'd1);
        #2 rst_n = 1'b0;
        #1 chk("store_we_drop", {15'd0, mem_we}, 16'd0);
        chk("store_state0", {13'd0, state}, 16'd0);
        chk("store_all_zero", 16'(observe()), 16'(mk(0)));
        @(posedge clk);
        #1 rst_n = 1'b1;

        idle_then_start(5);
        run_instr(0, rb(), 1, 0);
        run_instr(4, rb(), 0, 1);

        @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
